// File: rtl/io_input_pkg.sv
// Shared types and constants for the board input conditioner.
// Holds the conditioner FSM states, the core switch-word width and default sizing.
package io_input_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } cond_state_t;

  localparam int IO_SW_WIDTH         = 32;
  localparam int DEF_N_SW            = 10;
  localparam int DEF_N_KEY           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 100000;

  // The counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_ch.sv
// One input channel: flip-flop synchronizer, stability counter, accepted level
// and registered edge pulses that coincide with the level change.
module debounce_ch
  import io_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit INVERT          = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  input  logic i_prime,
  input  logic i_run,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable_q;
  logic [CW-1:0]          cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Polarity is fixed after the last stage so the chain itself stays plain.
  assign synced = sync_q[SYNC_STAGES-1] ^ INVERT;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      if (i_prime) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else if (i_run) begin
        if (synced == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_q <= synced;
          cnt_q    <= '0;
          o_rise   <= synced;
          o_fall   <= ~synced;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign o_level = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Board-to-core input path: synchronizes and debounces SW/KEY, packs the core
// switch word and generates key press/release, sticky press and switch-change flags.
module io_input_conditioner
  import io_input_pkg::*;
#(
  parameter int N_SW            = DEF_N_SW,
  parameter int N_KEY           = DEF_N_KEY,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_SW-1:0]        i_sw_raw,
  input  logic [N_KEY-1:0]       i_key_raw,
  input  logic [N_KEY-1:0]       i_press_clr,
  output logic [IO_SW_WIDTH-1:0] o_io_sw,
  output logic [N_KEY-1:0]       o_key_press,
  output logic [N_KEY-1:0]       o_key_release,
  output logic [N_KEY-1:0]       o_key_sticky,
  output logic [N_SW-1:0]        o_sw_change,
  output logic                   o_ready,
  output logic [1:0]             o_state
);

  localparam int IW = $clog2(SYNC_STAGES + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES - 1);

  cond_state_t   state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic          prime, run;

  logic [N_SW-1:0]  sw_level, sw_rise, sw_fall;
  logic [N_KEY-1:0] key_level;
  logic [N_KEY-1:0] sticky_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // INIT waits until every synchronizer stage holds a real sample before PRIME.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = PRIME;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      PRIME:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign prime   = (state_q == PRIME);
  assign run     = (state_q == RUN);
  assign o_ready = run;
  assign o_state = state_q;

  for (genvar s = 0; s < N_SW; s++) begin : g_sw
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b0)
    ) u_ch (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_raw  (i_sw_raw[s]),
      .i_prime(prime),
      .i_run  (run),
      .o_level(sw_level[s]),
      .o_rise (sw_rise[s]),
      .o_fall (sw_fall[s])
    );
  end

  // Keys are active-low on the board; the channel inverts so clean 1 means pressed.
  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b1)
    ) u_ch (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_raw  (i_key_raw[k]),
      .i_prime(prime),
      .i_run  (run),
      .o_level(key_level[k]),
      .o_rise (o_key_press[k]),
      .o_fall (o_key_release[k])
    );
  end

  // Sticky sets from the registered press pulse, so a clear in the pulse cycle loses.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~(run ? i_press_clr : '0)) | o_key_press;
    end
  end

  assign o_key_sticky = sticky_q;
  assign o_sw_change  = sw_rise | sw_fall;
  assign o_io_sw      = IO_SW_WIDTH'({key_level, sw_level});

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner with a window-based reference model.
module tb_io_input_conditioner;
  import io_input_pkg::*;

  localparam int N_SW   = 10;
  localparam int N_KEY  = 4;
  localparam int SS     = 2;
  localparam int DC     = 4;
  localparam int NCH    = N_SW + N_KEY;
  localparam int HIST_N = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_SW-1:0]   sw_raw = 10'h155;
  logic [N_KEY-1:0]  key_raw = 4'hF;
  logic [N_KEY-1:0]  press_clr = '0;
  logic [31:0]       o_io_sw;
  logic [N_KEY-1:0]  o_key_press, o_key_release, o_key_sticky;
  logic [N_SW-1:0]   o_sw_change;
  logic              o_ready;
  logic [1:0]        o_state;

  int checks = 0;
  int errors = 0;

  io_input_conditioner #(
    .N_SW(N_SW), .N_KEY(N_KEY), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_sw_raw     (sw_raw),
    .i_key_raw    (key_raw),
    .i_press_clr  (press_clr),
    .o_io_sw      (o_io_sw),
    .o_key_press  (o_key_press),
    .o_key_release(o_key_release),
    .o_key_sticky (o_key_sticky),
    .o_sw_change  (o_sw_change),
    .o_ready      (o_ready),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once DC consecutive run cycles since its last
  // change all saw the synchronized (SS-cycle-old) raw value disagree with it.
  logic [NCH-1:0]   hist [0:HIST_N-1];
  int               g = 0;
  int               rel = 0;
  int               last_chg [NCH];
  logic [NCH-1:0]   m_lvl = '0, m_rise = '0, m_fall = '0, m_cur;
  logic [N_KEY-1:0] m_sticky = '0;
  logic             m_ready = 1'b0;
  bit               m_ok;

  task automatic model_reset();
    m_lvl = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_ready = 1'b0; rel = 0;
  endtask

  task automatic model_edge();
    m_cur = {~key_raw, sw_raw};
    g = g + 1;
    hist[g % HIST_N] = m_cur;
    rel = rel + 1;
    if (m_ready) m_sticky = (m_sticky & ~press_clr) | m_rise[NCH-1:N_SW];
    m_rise = '0;
    m_fall = '0;
    if (rel == SS + 1) begin
      m_lvl = hist[(g - SS) % HIST_N];
      for (int c = 0; c < NCH; c++) last_chg[c] = g;
      m_ready = 1'b1;
    end else if (rel > SS + 1) begin
      for (int c = 0; c < NCH; c++) begin
        m_ok = 1'b1;
        for (int j = 0; j < DC; j++)
          if ((g - j) <= last_chg[c] || hist[(g - j - SS) % HIST_N][c] == m_lvl[c]) m_ok = 1'b0;
        if (m_ok) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) m_rise[c] = 1'b1;
          else          m_fall[c] = 1'b1;
          last_chg[c] = g;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_edge();
  end

  logic [54:0] obs_vec, exp_vec;
  assign obs_vec = {o_io_sw, o_key_press, o_key_release, o_key_sticky, o_sw_change, o_ready};
  assign exp_vec = {{(32-NCH){1'b0}}, m_lvl, m_rise[NCH-1:N_SW], m_fall[NCH-1:N_SW], m_sticky,
                    m_rise[N_SW-1:0] | m_fall[N_SW-1:0], m_ready};

  task automatic test_reset();
    int ready_at = -1;
    key_raw = 4'hF; sw_raw = 10'h155; press_clr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec !== '0) begin errors++; $display("FAIL reset_zero got %h exp 0", obs_vec); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
      checks++;
      if ((o_key_press | o_key_release) !== '0 || o_sw_change !== '0) begin
        errors++; $display("FAIL prime_pulse cyc %0d got %h/%h/%h exp 0", i, o_key_press, o_key_release, o_sw_change);
      end
      if (o_ready === 1'b1 && ready_at < 0) ready_at = i;
    end
    checks++;
    if (ready_at < 0 || ready_at > 3) begin errors++; $display("FAIL ready_latency got %0d exp <=3", ready_at); end
    checks++;
    if (o_io_sw !== 32'h0000_0155) begin errors++; $display("FAIL prime_io_sw got %h exp 00000155", o_io_sw); end
    checks++;
    if (o_state !== 2'(RUN)) begin errors++; $display("FAIL state_run got %0d exp %0d", o_state, RUN); end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int n_press = 0;
    int n_rel = 0;
    key_raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL press_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
      if (o_io_sw[11] === 1'b1 && first < 0) first = i;
      if (o_key_press === 4'b0010) n_press++;
      else if (o_key_press !== 4'b0000) n_press += 100;
    end
    checks++;
    if (first != SS + DC - 1) begin errors++; $display("FAIL press_latency got %0d exp %0d", first, SS + DC - 1); end
    checks++;
    if (n_press != 1) begin errors++; $display("FAIL press_pulse_count got %0d exp 1", n_press); end
    checks++;
    if (o_key_sticky !== 4'b0010) begin errors++; $display("FAIL press_sticky got %b exp 0010", o_key_sticky); end
    key_raw[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL release_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
      if (o_key_release === 4'b0010) n_rel++;
      else if (o_key_release !== 4'b0000) n_rel += 100;
    end
    checks++;
    if (n_rel != 1) begin errors++; $display("FAIL release_pulse_count got %0d exp 1", n_rel); end
    checks++;
    if (o_io_sw[11] !== 1'b0) begin errors++; $display("FAIL release_level got %b exp 0", o_io_sw[11]); end
  endtask

  task automatic test_bounce();
    int n_press = 0;
    int n_high = 0;
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 2; p++) begin
        key_raw[2] = (p == 0) ? 1'b0 : 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checks++;
          if (obs_vec !== exp_vec) begin errors++; $display("FAIL bounce_model rep %0d got %h exp %h", r, obs_vec, exp_vec); end
          if (o_key_press !== 4'b0000) n_press++;
          if (o_io_sw[12] !== 1'b0) n_high++;
        end
      end
    end
    checks++;
    if (n_press != 0) begin errors++; $display("FAIL bounce_press got %0d exp 0", n_press); end
    checks++;
    if (n_high != 0) begin errors++; $display("FAIL bounce_level got %0d exp 0", n_high); end
  endtask

  task automatic test_sticky_contention();
    bit seen = 1'b0;
    press_clr = 4'b0010;
    @(negedge clk);
    press_clr = 4'b0000;
    checks++;
    if (o_key_sticky[1] !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b exp 0", o_key_sticky[1]); end
    key_raw[1] = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL contention_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
      if (o_key_press[1] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL contention_press_timeout got 0 exp 1"); end
    press_clr = 4'b0010;
    @(negedge clk);
    checks++;
    if (o_key_sticky[1] !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %b exp 1", o_key_sticky[1]); end
    @(negedge clk);
    checks++;
    if (o_key_sticky[1] !== 1'b0) begin errors++; $display("FAIL sticky_clear_after got %b exp 0", o_key_sticky[1]); end
    press_clr = 4'b0000;
    key_raw[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL contention_rel_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_switch_edge();
    int n_ok = 0;
    int n_bad = 0;
    sw_raw = 10'h354;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL switch_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
      if (o_sw_change === 10'h201) n_ok++;
      else if (o_sw_change !== 10'h000) n_bad++;
    end
    checks++;
    if (n_ok != 1 || n_bad != 0) begin errors++; $display("FAIL switch_change got %0d/%0d exp 1/0", n_ok, n_bad); end
    checks++;
    if (o_io_sw[9:0] !== 10'h354) begin errors++; $display("FAIL switch_level got %h exp 354", o_io_sw[9:0]); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] raw;
    raw = {key_raw, sw_raw};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, NCH - 1)] ^= 1'b1;
      {key_raw, sw_raw} = raw;
      press_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
    end
    press_clr = '0;
  endtask

  task automatic test_reset_midcount();
    int n_press = 0;
    key_raw = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL midcount_settle cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
    end
    key_raw[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", obs_vec); end
    @(negedge clk);
    checks++;
    if (obs_vec !== '0) begin errors++; $display("FAIL reset_hold got %h exp 0", obs_vec); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL midcount_model cyc %0d got %h exp %h", i, obs_vec, exp_vec); end
      if (o_key_press !== 4'b0000) n_press++;
    end
    checks++;
    if (n_press != 0) begin errors++; $display("FAIL reprime_press got %0d exp 0", n_press); end
    checks++;
    if (o_io_sw[10] !== 1'b1 || o_ready !== 1'b1) begin
      errors++; $display("FAIL reprime_level got %b/%b exp 1/1", o_io_sw[10], o_ready);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_sticky_contention();
    test_switch_edge();
    test_random();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Board-to-core input path: the reader counterpart to the core's LED/HEX output drive.
- Synchronizes raw DE10-Standard SW[9:0] and KEY[3:0] into the core clock domain and debounces each channel.
- Converts KEY from active-low to active-high.
- Presents the 32-bit switch word consumed by the pipelined core's i_io_sw, plus per-key press/release pulses, a sticky press latch and switch-change pulses.
- Sits between the board pins and pipelined core in the top-level wrapper, clocked by the divided core clock.

Parameters:
- N_SW, 10, number of slide switches.
- N_KEY, 4, number of push buttons.
- SYNC_STAGES, 2, flip-flop synchronizer depth (>=2).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a new level (10 ms at 10 MHz); >=1.

Ports:
- i_clk  in  1  core clock (divided board clock)
- i_reset  in  1  asynchronous active-low reset
- i_sw_raw  in  N_SW  raw slide switches, asynchronous
- i_key_raw  in  N_KEY  raw push buttons, active-low, asynchronous
- i_press_clr  in  N_KEY  write-1-to-clear for o_key_sticky, synchronous
- o_io_sw  out  32  {zero pad, key_clean[N_KEY-1:0], sw_clean[N_SW-1:0]}; bits above N_SW+N_KEY are 0
- o_key_press  out  N_KEY  1-cycle pulse on debounced press
- o_key_release  out  N_KEY  1-cycle pulse on debounced release
- o_key_sticky  out  N_KEY  latched press flags
- o_sw_change  out  N_SW  1-cycle pulse on any debounced switch transition
- o_ready  out  1  high once the block is in RUN state

Behaviour:
- Reset (i_reset=0, asynchronous):
  - All outputs 0; synchronizers, counters and stable registers cleared.
  - Key stable registers hold the "released" value (clean 0).
  - FSM enters INIT.
- FSM:
  - INIT: counts SYNC_STAGES cycles so the synchronizers fill -> PRIME.
  - PRIME: one cycle. Every stable register loads its synchronized value directly, with no pulses and counters at 0 -> RUN. o_ready rises on the transition into RUN.
  - RUN: terminal until reset.
- Synchronization: SYNC_STAGES-deep flip-flop chain per channel. KEY is inverted after the last stage.
- Debounce, per channel, RUN only:
  - If synced == stable, counter <= 0.
  - Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1 and the mismatch persists, stable <= synced and counter <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency: a raw edge stable from cycle 0 shows in o_io_sw at cycle SYNC_STAGES+DEBOUNCE_CYCLES (+1 for sampling phase).
- Glitches: any mismatch shorter than DEBOUNCE_CYCLES is discarded with no output change and no pulse.
- Pulses:
  - All pulses are registered and asserted in the same cycle the corresponding o_io_sw bit changes.
  - o_key_press on clean 0->1; o_key_release on clean 1->0; o_sw_change on either switch edge.
  - Never asserted outside RUN or during the PRIME load.
- Sticky flags:
  - o_key_sticky[i] sets on o_key_press[i] and clears on i_press_clr[i]=1.
  - Set and clear in the same cycle: set wins.
  - Clears ignored outside RUN.
- Channels are independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-count: all counters lost, FSM restarts at INIT, o_ready drops immediately.

Decomposition:
- Package io_input_pkg holds:
  - enum cond_state_t {INIT, PRIME, RUN}
  - IO_SW_WIDTH=32
  - default width and debounce constants
- Sub-module debounce_ch: one channel covering synchronizer, counter, stable register and edge pulses, with ports i_clk, i_reset, i_raw, i_prime, i_run, o_level, o_rise, o_fall.
- Top level instantiates N_SW+N_KEY debounce_ch instances via generate, plus the FSM, sticky latches and output packing.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Reset/prime: hold i_key_raw=4'hF, i_sw_raw=10'h155, release reset.
   -> o_ready=1 and o_io_sw=32'h0000_0155 within 4 cycles, all pulses 0 throughout.
2. Clean press: i_key_raw[1] 1->0 and held.
   -> o_io_sw[11] rises 6 cycles later; o_key_press=4'b0010 for exactly 1 cycle; o_key_sticky=4'b0010.
   Then release -> o_key_release=4'b0010 pulse, o_io_sw[11]=0.
3. Bounce: i_key_raw[2] low for 3 cycles then high, repeated 5 times.
   -> o_io_sw[12] stays 0, no o_key_press.
4. Sticky contention: i_press_clr=4'b0010 in the same cycle as o_key_press[1] -> sticky[1] stays 1.
   i_press_clr=4'b0010 alone next cycle -> sticky[1]=0.
5. Switch edge: i_sw_raw[0] 1->0 and simultaneously i_sw_raw[9] 0->1.
   -> o_sw_change=10'h201 for one cycle, o_io_sw[9:0]=10'h354.
6. Reset mid-count: i_key_raw[0] low for 3 cycles, then pulse i_reset low.
   -> o_io_sw, pulses and o_ready are 0 during reset; after release the block re-primes to the current raw levels with no o_key_press pulse.
